// File: rtl/piezo_sched_pkg.sv
// Shared state encoding and default sizing for the piezo burst scheduler.
// The enum values double as the status code reported to software.
package piezo_sched_pkg;
  localparam int NUM_CH_DEF = 61;
  localparam int IDX_W_DEF  = 6;
  localparam int TS_W_DEF   = 64;

  localparam logic [2:0] STATUS_IDLE      = 3'd0;
  localparam logic [2:0] STATUS_WAIT_TIME = 3'd1;
  localparam logic [2:0] STATUS_SELECT    = 3'd2;
  localparam logic [2:0] STATUS_BURST     = 3'd3;
  localparam logic [2:0] STATUS_GUARD     = 3'd4;
  localparam logic [2:0] STATUS_DONE      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = STATUS_IDLE,
    ST_WAIT_TIME = STATUS_WAIT_TIME,
    ST_SELECT    = STATUS_SELECT,
    ST_BURST     = STATUS_BURST,
    ST_GUARD     = STATUS_GUARD,
    ST_DONE      = STATUS_DONE
  } state_t;
endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator for one burst: counts cycles within a half-period
// and half-periods within the burst. Zero-valued configs behave as 1.
module piezo_tone_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] half_period,
  input  logic [7:0]  burst_len,
  output logic        level,
  output logic        last
);
  logic [15:0] hp_cnt;
  logic [8:0]  hp_num;
  logic        lvl;
  logic [15:0] hp_end;
  logic [8:0]  num_end;
  logic        wrap;

  assign hp_end  = (half_period == 16'd0) ? 16'd0 : half_period - 16'd1;
  assign num_end = (burst_len == 8'd0) ? 9'd1 : {burst_len, 1'b0} - 9'd1;
  assign wrap    = (hp_cnt == hp_end);
  assign last    = wrap && (hp_num == num_end);
  // level is the drive value for the following cycle, so the caller can register it.
  assign level   = load ? 1'b1 : (wrap ? ~lvl : lvl);

  always_ff @(posedge clk) begin
    if (reset) begin
      hp_cnt <= '0;
      hp_num <= '0;
      lvl    <= 1'b0;
    end else if (load) begin
      hp_cnt <= '0;
      hp_num <= '0;
      lvl    <= 1'b1;
    end else if (wrap) begin
      hp_cnt <= '0;
      hp_num <= hp_num + 9'd1;
      lvl    <= ~lvl;
    end else begin
      hp_cnt <= hp_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/piezo_burst_scheduler.sv
// Scans a latched channel mask, firing one piezo at a time with a square-wave
// burst followed by a guard gap, and timestamps each burst start.
module piezo_burst_scheduler
  import piezo_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int TS_W   = TS_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              timed_start,
  input  logic [TS_W-1:0]   sched_time,
  input  logic [TS_W-1:0]   rtc_time,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [7:0]        burst_len,
  input  logic [15:0]       half_period,
  input  logic [15:0]       guard_len,
  output logic [NUM_CH-1:0] piezo_out,
  output logic              piezo_enable,
  output logic [2:0]        status,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  cur_ch,
  output logic [TS_W-1:0]   stamp,
  output logic              stamp_valid
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [NUM_CH-1:0] mask_q;
  logic [7:0]        bl_q;
  logic [15:0]       hp_q;
  logic [15:0]       gl_q;
  logic [TS_W-1:0]   sched_q;
  logic [15:0]       g_cnt;
  logic [15:0]       g_end;
  logic              tone_load;
  logic              tone_level;
  logic              tone_last;

  assign status    = state;
  assign cur_ch    = idx;
  assign g_end     = (gl_q == 16'd0) ? 16'd0 : gl_q - 16'd1;
  assign tone_load = (state == ST_SELECT) && mask_q[idx];

  piezo_tone_gen u_tone (
    .clk         (clk),
    .reset       (reset),
    .load        (tone_load),
    .half_period (hp_q),
    .burst_len   (bl_q),
    .level       (tone_level),
    .last        (tone_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      mask_q       <= '0;
      bl_q         <= '0;
      hp_q         <= '0;
      gl_q         <= '0;
      sched_q      <= '0;
      g_cnt        <= '0;
      piezo_out    <= '0;
      piezo_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      stamp        <= '0;
      stamp_valid  <= 1'b0;
    end else begin
      done        <= 1'b0;
      stamp_valid <= 1'b0;
      if (abort) begin
        state        <= ST_IDLE;
        piezo_out    <= '0;
        piezo_enable <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              mask_q  <= ch_mask;
              bl_q    <= burst_len;
              hp_q    <= half_period;
              gl_q    <= guard_len;
              sched_q <= sched_time;
              idx     <= '0;
              busy    <= 1'b1;
              if (timed_start) begin
                state <= ST_WAIT_TIME;
              end else begin
                state        <= ST_SELECT;
                piezo_enable <= 1'b1;
              end
            end
          end
          ST_WAIT_TIME: begin
            if (rtc_time >= sched_q) begin
              state        <= ST_SELECT;
              piezo_enable <= 1'b1;
            end
          end
          ST_SELECT: begin
            if (mask_q[idx]) begin
              state          <= ST_BURST;
              piezo_out[idx] <= tone_level;
              stamp          <= rtc_time;
              stamp_valid    <= 1'b1;
            end else if (idx == LAST_IDX) begin
              state        <= ST_DONE;
              done         <= 1'b1;
              piezo_enable <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          ST_BURST: begin
            // Only bit idx is ever set, so writing that bit keeps the drive one-hot.
            if (tone_last) begin
              state     <= ST_GUARD;
              piezo_out <= '0;
              g_cnt     <= '0;
            end else begin
              piezo_out[idx] <= tone_level;
            end
          end
          ST_GUARD: begin
            if (g_cnt == g_end) begin
              if (idx == LAST_IDX) begin
                state        <= ST_DONE;
                done         <= 1'b1;
                piezo_enable <= 1'b0;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= ST_SELECT;
              end
            end else begin
              g_cnt <= g_cnt + 16'd1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
